// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: ROM read port, decode slot handshake, redirect, halt.
// master = fetch_ctrl, slave = ROM/decode/execute side.
interface fetch_ctrl_if;
    logic [7:0] rom_data;
    logic [7:0] rom_addr;
    logic       rom_read;
    logic       rom_ena;
    logic       inst_valid;
    logic       inst_ready;
    logic [7:0] inst_ir;
    logic [7:0] inst_operand;
    logic [7:0] inst_pc;
    logic       redir_valid;
    logic [7:0] redir_pc;
    logic       halted;

    modport master (
        input  rom_data, inst_ready, redir_valid, redir_pc,
        output rom_addr, rom_read, rom_ena,
        output inst_valid, inst_ir, inst_operand, inst_pc, halted
    );

    modport slave (
        output rom_data, inst_ready, redir_valid, redir_pc,
        input  rom_addr, rom_read, rom_ena,
        input  inst_valid, inst_ir, inst_operand, inst_pc, halted
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns pc, reads the ROM, assembles 1/2-byte
// instructions into a valid/ready slot. Ports: clk, rst_n (sync), bus.
module fetch_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        S_FETCH,
        S_ARG,
        S_HALT
    } state_t;

    state_t     state, state_n;
    logic [7:0] pc, pc_n;
    logic [7:0] op_lat, op_lat_n;
    logic       valid, valid_n;
    logic [7:0] ir, ir_n;
    logic [7:0] opnd, opnd_n;
    logic [7:0] ipc, ipc_n;
    logic       halt, halt_n;
    logic       strobe;
    logic       slot_free;
    logic       is_two;
    logic       is_hlt;

    assign slot_free = !valid || bus.inst_ready;
    assign is_two = (bus.rom_data[7:5] == 3'b001)
                 || (bus.rom_data[7:5] == 3'b010)
                 || (bus.rom_data[7:5] == 3'b011);
    assign is_hlt = (bus.rom_data[7:5] == 3'b111);

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        op_lat_n = op_lat;
        valid_n  = valid;
        ir_n     = ir;
        opnd_n   = opnd;
        ipc_n    = ipc;
        halt_n   = halt;
        strobe   = 1'b0;
        if (bus.redir_valid) begin
            // Redirect wins even over a handshake in the same cycle.
            pc_n    = bus.redir_pc;
            valid_n = 1'b0;
            halt_n  = 1'b0;
            state_n = S_FETCH;
        end else begin
            unique case (state)
                S_FETCH: begin
                    strobe = slot_free;
                    if (slot_free) begin
                        pc_n    = pc + 8'd1;
                        valid_n = 1'b0;
                        unique case (1'b1)
                            is_two: begin
                                op_lat_n = bus.rom_data;
                                state_n  = S_ARG;
                            end
                            is_hlt: begin
                                valid_n = 1'b1;
                                ir_n    = bus.rom_data;
                                opnd_n  = 8'h00;
                                ipc_n   = pc;
                                halt_n  = 1'b1;
                                state_n = S_HALT;
                            end
                            default: begin
                                valid_n = 1'b1;
                                ir_n    = bus.rom_data;
                                opnd_n  = 8'h00;
                                ipc_n   = pc;
                            end
                        endcase
                    end
                end
                S_ARG: begin
                    // Slot was freed when the opcode byte was taken.
                    strobe  = 1'b1;
                    valid_n = 1'b1;
                    ir_n    = op_lat;
                    opnd_n  = bus.rom_data;
                    ipc_n   = pc - 8'd1;
                    pc_n    = pc + 8'd1;
                    state_n = S_FETCH;
                end
                S_HALT: begin
                    valid_n = valid && !bus.inst_ready;
                end
                default: begin
                    state_n = S_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_FETCH;
            pc     <= 8'h00;
            op_lat <= 8'h00;
            valid  <= 1'b0;
            ir     <= 8'h00;
            opnd   <= 8'h00;
            ipc    <= 8'h00;
            halt   <= 1'b0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            op_lat <= op_lat_n;
            valid  <= valid_n;
            ir     <= ir_n;
            opnd   <= opnd_n;
            ipc    <= ipc_n;
            halt   <= halt_n;
        end
    end

    assign bus.rom_addr     = pc;
    assign bus.rom_read     = strobe && rst_n;
    assign bus.rom_ena      = strobe && rst_n;
    assign bus.inst_valid   = valid;
    assign bus.inst_ir      = ir;
    assign bus.inst_operand = opnd;
    assign bus.inst_pc      = ipc;
    assign bus.halted       = halt;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed steps plus random ready/redirect/reset,
// checked against an instruction-stream scoreboard built from the ROM.
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fetch_ctrl_if bus ();

    fetch_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [256];
    assign bus.rom_data = rom[bus.rom_addr];

    int checks = 0;
    int passes = 0;
    logic [23:0] expq [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Program-order instruction stream from a start address, up to HLT.
    function automatic void build(input logic [7:0] start);
        logic [7:0] p;
        logic [7:0] op;
        logic [7:0] nx;
        p = start;
        expq.delete();
        for (int n = 0; n < 512; n++) begin
            op = rom[p];
            nx = p + 8'd1;
            if (op[7:5] inside {3'd1, 3'd2, 3'd3}) begin
                expq.push_back({op, rom[nx], p});
                p = p + 8'd2;
            end else begin
                expq.push_back({op, 8'h00, p});
                p = nx;
                if (op[7:5] == 3'b111) break;
            end
        end
    endfunction

    function automatic logic [31:0] slot();
        return 32'({bus.inst_ir, bus.inst_operand, bus.inst_pc});
    endfunction

    task automatic tick();
        logic rs, redir, xfer, hold;
        logic [7:0] rdpc;
        logic [31:0] held;
        logic [23:0] e;
        #1;
        rs    = rst_n;
        redir = bus.redir_valid;
        rdpc  = bus.redir_pc;
        held  = slot();
        xfer  = rs && !redir && bus.inst_valid && bus.inst_ready;
        hold  = rs && !redir && bus.inst_valid && !bus.inst_ready;
        chk("ena_eq_read", 32'(bus.rom_ena), 32'(bus.rom_read));
        if (!rs || redir || hold || bus.halted)
            chk("strobe_low", 32'(bus.rom_read), 32'd0);
        if (xfer) begin
            chk("xfer_expected", 32'(expq.size() != 0), 32'd1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("xfer_slot", slot(), 32'(e));
            end
        end
        @(posedge clk);
        #1;
        if (!rs) begin
            build(8'h00);
            chk("rst_valid", 32'(bus.inst_valid), 32'd0);
            chk("rst_slot", slot(), 32'd0);
            chk("rst_pc", 32'(bus.rom_addr), 32'd0);
            chk("rst_halted", 32'(bus.halted), 32'd0);
        end else if (redir) begin
            build(rdpc);
            chk("redir_valid", 32'(bus.inst_valid), 32'd0);
            chk("redir_halted", 32'(bus.halted), 32'd0);
            chk("redir_pc", 32'(bus.rom_addr), 32'(rdpc));
        end else if (hold) begin
            chk("hold_valid", 32'(bus.inst_valid), 32'd1);
            chk("hold_slot", slot(), held);
        end
        if (bus.inst_valid && bus.inst_ir[7:5] == 3'b111)
            chk("halted_on_hlt", 32'(bus.halted), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[1] = 8'h41; rom[2] = 8'h03; rom[3] = 8'h81;
        rom[4] = 8'hA1; rom[5] = 8'h22; rom[6] = 8'h09;
        rom[7] = 8'hC2; rom[8] = 8'h63; rom[9] = 8'h11;
        for (int i = 10; i < 19; i++) rom[i] = 8'(8'h80 + i);
        rom[19] = 8'hE0;
        bus.inst_ready  = 1'b1;
        bus.redir_valid = 1'b0;
        bus.redir_pc    = 8'h00;
        rst_n = 1'b0;
        tick();
        tick();

        rst_n = 1'b1;
        #1;
        chk("fetch0_strobe", 32'(bus.rom_read), 32'd1);
        chk("fetch0_addr", 32'(bus.rom_addr), 32'd0);
        tick();
        chk("nop_valid", 32'(bus.inst_valid), 32'd1);
        chk("nop_slot", slot(), 32'h00_00_00);
        chk("nop_next_addr", 32'(bus.rom_addr), 32'd1);
        tick();
        chk("lda_gap_valid", 32'(bus.inst_valid), 32'd0);
        chk("lda_arg_addr", 32'(bus.rom_addr), 32'd2);
        tick();
        chk("lda_slot", slot(), 32'h41_03_01);
        tick();
        chk("pre_slot", slot(), 32'h81_00_03);
        chk("pre_next_addr", 32'(bus.rom_addr), 32'd4);

        bus.inst_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            #1;
            chk("stall_strobe", 32'(bus.rom_read), 32'd0);
            tick();
            chk("stall_pc", 32'(bus.rom_addr), 32'd4);
        end
        chk("stall_slot", slot(), 32'h81_00_03);
        bus.inst_ready = 1'b1;
        #1;
        chk("release_strobe", 32'(bus.rom_read), 32'd1);
        tick();
        chk("resume_slot", slot(), 32'hA1_00_04);

        for (int n = 0; n < 40 && !bus.halted; n++) tick();
        chk("hlt_halted", 32'(bus.halted), 32'd1);
        chk("hlt_pc", 32'(bus.rom_addr), 32'd20);
        tick();
        tick();
        chk("halt_pc_frozen", 32'(bus.rom_addr), 32'd20);
        chk("halt_drained", 32'(bus.inst_valid), 32'd0);
        chk("halt_stays", 32'(bus.halted), 32'd1);

        bus.redir_valid = 1'b1;
        bus.redir_pc    = 8'h07;
        tick();
        bus.redir_valid = 1'b0;
        #1;
        chk("redir_fetch_strobe", 32'(bus.rom_read), 32'd1);
        tick();
        chk("redir_first_slot", slot(), 32'hC2_00_07);
        chk("redir_first_valid", 32'(bus.inst_valid), 32'd1);

        rom[0]   = 8'h05;
        rom[255] = 8'h62;
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 8'hFF;
        tick();
        bus.redir_valid = 1'b0;
        tick();
        chk("wrap_gap_valid", 32'(bus.inst_valid), 32'd0);
        tick();
        chk("wrap_slot", slot(), 32'h62_05_FF);
        chk("wrap_pc", 32'(bus.rom_addr), 32'd1);

        bus.redir_valid = 1'b1;
        bus.redir_pc    = 8'h01;
        tick();
        bus.redir_valid = 1'b0;
        tick();
        chk("arg_entry_addr", 32'(bus.rom_addr), 32'd2);
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 8'h03;
        tick();
        bus.redir_valid = 1'b0;
        tick();
        chk("arg_redir_slot", slot(), 32'h81_00_03);

        bus.redir_valid = 1'b1;
        bus.redir_pc    = 8'h01;
        tick();
        bus.redir_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("arg_rst_slot", slot(), 32'h05_00_00);

        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 8'($urandom);
        tick();
        for (int n = 0; n < 3000; n++) begin
            bus.inst_ready  = ($urandom_range(0, 9) < 7);
            bus.redir_valid = ($urandom_range(0, 19) == 0);
            bus.redir_pc    = 8'($urandom);
            rst_n           = ($urandom_range(0, 199) != 0);
            if (bus.redir_valid && $urandom_range(0, 3) == 0)
                for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
